// File: rtl/ex_pkg.sv
// Shared definitions for the execute->writeback stage.
// Op class codes, default widths, buffered entry layout, buffer states.
package ex_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 5;

  localparam logic [1:0] OP_ALU    = 2'd0;
  localparam logic [1:0] OP_BRANCH = 2'd1;
  localparam logic [1:0] OP_JAL    = 2'd2;
  localparam logic [1:0] OP_JALR   = 2'd3;

  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic [REGW_DEF-1:0] rd;
    logic                we;
    logic                excp;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/ex_wb_stage_skid_buf2.sv
// Two-entry skid buffer, FIFO order, count held as a 3-state FSM.
// Ports: clk, rst, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
import ex_pkg::*;

module skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t state;
  buf_state_t state_nx;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic push;
  logic pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BUF_EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      BUF_EMPTY: if (push) state_nx = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      state_nx = BUF_FULL;
        else if (!push && pop) state_nx = BUF_EMPTY;
      end
      BUF_FULL: if (pop) state_nx = BUF_ONE;
      default: state_nx = BUF_EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state != BUF_FULL);
    out_valid = (state != BUF_EMPTY);
  end

  // head is the oldest entry; tail only used while FULL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      unique case (state)
        BUF_EMPTY: if (push) head <= in_data;
        BUF_ONE: begin
          if (push && pop) head <= in_data;
          else if (push)   tail <= in_data;
        end
        BUF_FULL: if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  assign out_data = head;

endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB stage: resolves control transfers, buffers results for WB,
// pulses a fetch redirect. Ports: in_* from ALU, out_* to WB, redir_*.
import ex_pkg::*;

module ex_wb_stage #(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_q,
  input  logic            in_cmp,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [REGW-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [REGW-1:0] out_rd,
  output logic            out_we,
  output logic            out_excp,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc
);

  entry_t          ent;
  entry_t          head;
  logic            taken;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] link;
  logic            fire;

  assign link = in_pc + XLEN'(4);

  always_comb begin
    taken      = 1'b0;
    tgt        = '0;
    ent        = '0;
    ent.rd     = in_rd;
    ent.result = in_q;
    unique case (1'b1)
      (in_op == OP_BRANCH): begin
        taken = in_cmp;
        tgt   = in_pc + in_imm;
      end
      (in_op == OP_JAL): begin
        taken      = 1'b1;
        tgt        = in_pc + in_imm;
        ent.result = link;
      end
      (in_op == OP_JALR): begin
        taken      = 1'b1;
        tgt        = {in_q[XLEN-1:1], 1'b0};
        ent.result = link;
      end
      default: ;
    endcase
    // misaligned target traps instead of redirecting or writing rd
    ent.excp = taken & tgt[1];
    ent.we   = (in_op != OP_BRANCH) & (in_rd != '0) & ~ent.excp;
  end

  assign fire = in_valid & in_ready & taken & ~ent.excp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else begin
      redir_valid <= fire;
      redir_pc    <= fire ? tgt : '0;
    end
  end

  skid_buf2 #(
    .W(ENTRY_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (ent),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head)
  );

  assign out_result = head.result;
  assign out_rd     = head.rd;
  assign out_we     = head.we & out_valid;
  assign out_excp   = head.excp & out_valid;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed self-checking bench for ex_wb_stage.
// One task per scenario, hand-computed expectations.
module tb_ex_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_q;
  logic        in_cmp;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_excp;
  logic        redir_valid;
  logic [31:0] redir_pc;

  int n_cmp = 0;
  int n_bad = 0;

  ex_wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_q       (in_q),
    .in_cmp     (in_cmp),
    .in_pc      (in_pc),
    .in_imm     (in_imm),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .out_excp   (out_excp),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] op, input logic [31:0] q,
                       input logic cmp, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [4:0] rd);
    in_op  = op;
    in_q   = q;
    in_cmp = cmp;
    in_pc  = pc;
    in_imm = imm;
    in_rd  = rd;
  endtask

  task automatic push(input logic [1:0] op, input logic [31:0] q,
                      input logic cmp, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [4:0] rd);
    @(negedge clk);
    drive(op, q, cmp, pc, imm, rd);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_result !== 32'h0) begin n_bad++; $display("FAIL rst_result: got %h want 0", out_result); end
    n_cmp++; if (out_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", out_we); end
    n_cmp++; if (out_excp !== 1'b0) begin n_bad++; $display("FAIL rst_excp: got %b want 0", out_excp); end
    n_cmp++; if (redir_valid !== 1'b0) begin n_bad++; $display("FAIL rst_redir: got %b want 0", redir_valid); end
    n_cmp++; if (redir_pc !== 32'h0) begin n_bad++; $display("FAIL rst_redir_pc: got %h want 0", redir_pc); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_alu;
    out_ready = 1'b1;
    push(2'd0, 32'h0000_0005, 1'b0, 32'h80, 32'h0, 5'd3);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL alu_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_result !== 32'h5) begin n_bad++; $display("FAIL alu_result: got %h want 5", out_result); end
    n_cmp++; if (out_rd !== 5'd3) begin n_bad++; $display("FAIL alu_rd: got %0d want 3", out_rd); end
    n_cmp++; if (out_we !== 1'b1) begin n_bad++; $display("FAIL alu_we: got %b want 1", out_we); end
    n_cmp++; if (redir_valid !== 1'b0) begin n_bad++; $display("FAIL alu_redir: got %b want 0", redir_valid); end
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL alu_pop_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_we !== 1'b0) begin n_bad++; $display("FAIL alu_pop_we: got %b want 0", out_we); end
    n_cmp++; if (out_result !== 32'h5) begin n_bad++; $display("FAIL alu_hold_result: got %h want 5", out_result); end
  endtask

  task automatic test_branch;
    out_ready = 1'b1;
    push(2'd1, 32'h0, 1'b1, 32'h100, 32'h20, 5'd7);
    n_cmp++; if (redir_valid !== 1'b1) begin n_bad++; $display("FAIL br_redir: got %b want 1", redir_valid); end
    n_cmp++; if (redir_pc !== 32'h120) begin n_bad++; $display("FAIL br_redir_pc: got %h want 120", redir_pc); end
    n_cmp++; if (out_we !== 1'b0) begin n_bad++; $display("FAIL br_we: got %b want 0", out_we); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL br_valid: got %b want 1", out_valid); end
    @(posedge clk);
    #1;
    n_cmp++; if (redir_valid !== 1'b0) begin n_bad++; $display("FAIL br_pulse: got %b want 0", redir_valid); end
    push(2'd1, 32'h0, 1'b0, 32'h100, 32'h20, 5'd7);
    n_cmp++; if (redir_valid !== 1'b0) begin n_bad++; $display("FAIL br_nt_redir: got %b want 0", redir_valid); end
    n_cmp++; if (out_excp !== 1'b0) begin n_bad++; $display("FAIL br_nt_excp: got %b want 0", out_excp); end
  endtask

  task automatic test_jalr;
    out_ready = 1'b1;
    push(2'd3, 32'h0000_2001, 1'b0, 32'h40, 32'h0, 5'd1);
    n_cmp++; if (redir_valid !== 1'b1) begin n_bad++; $display("FAIL jalr_redir: got %b want 1", redir_valid); end
    n_cmp++; if (redir_pc !== 32'h2000) begin n_bad++; $display("FAIL jalr_redir_pc: got %h want 2000", redir_pc); end
    n_cmp++; if (out_result !== 32'h44) begin n_bad++; $display("FAIL jalr_result: got %h want 44", out_result); end
    n_cmp++; if (out_we !== 1'b1) begin n_bad++; $display("FAIL jalr_we: got %b want 1", out_we); end
    n_cmp++; if (out_excp !== 1'b0) begin n_bad++; $display("FAIL jalr_excp: got %b want 0", out_excp); end
    push(2'd3, 32'h0000_2002, 1'b0, 32'h40, 32'h0, 5'd1);
    n_cmp++; if (out_excp !== 1'b1) begin n_bad++; $display("FAIL jalr_mis_excp: got %b want 1", out_excp); end
    n_cmp++; if (out_we !== 1'b0) begin n_bad++; $display("FAIL jalr_mis_we: got %b want 0", out_we); end
    n_cmp++; if (redir_valid !== 1'b0) begin n_bad++; $display("FAIL jalr_mis_redir: got %b want 0", redir_valid); end
  endtask

  task automatic test_jal_wrap;
    out_ready = 1'b1;
    push(2'd2, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h8, 5'd0);
    n_cmp++; if (redir_valid !== 1'b1) begin n_bad++; $display("FAIL jal_redir: got %b want 1", redir_valid); end
    n_cmp++; if (redir_pc !== 32'h4) begin n_bad++; $display("FAIL jal_redir_pc: got %h want 4", redir_pc); end
    n_cmp++; if (out_result !== 32'h0) begin n_bad++; $display("FAIL jal_result: got %h want 0", out_result); end
    n_cmp++; if (out_we !== 1'b0) begin n_bad++; $display("FAIL jal_we_rd0: got %b want 0", out_we); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    @(negedge clk);
    drive(2'd0, 32'h11, 1'b0, 32'h0, 32'h0, 5'd1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
    @(negedge clk);
    drive(2'd0, 32'h22, 1'b0, 32'h0, 32'h0, 5'd2);
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full: got %b want 0", in_ready); end
    @(negedge clk);
    drive(2'd0, 32'h33, 1'b0, 32'h0, 32'h0, 5'd3);
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got %b want 0", in_ready); end
    n_cmp++; if (out_result !== 32'h11) begin n_bad++; $display("FAIL b2b_hold: got %h want 11", out_result); end
    n_cmp++; if (out_rd !== 5'd1) begin n_bad++; $display("FAIL b2b_hold_rd: got %0d want 1", out_rd); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (out_result !== 32'h22) begin n_bad++; $display("FAIL b2b_second: got %h want 22", out_result); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_reopen: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++; if (out_result !== 32'h33) begin n_bad++; $display("FAIL b2b_third: got %h want 33", out_result); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_third_v: got %b want 1", out_valid); end
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    push(2'd0, 32'h7, 1'b0, 32'h0, 32'h0, 5'd5);
    push(2'd1, 32'h0, 1'b1, 32'h200, 32'h10, 5'd0);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_full: got %b want 0", in_ready); end
    n_cmp++; if (redir_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pend: got %b want 1", redir_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_result !== 32'h0) begin n_bad++; $display("FAIL mid_result: got %h want 0", out_result); end
    n_cmp++; if (out_rd !== 5'd0) begin n_bad++; $display("FAIL mid_rd: got %0d want 0", out_rd); end
    n_cmp++; if (redir_valid !== 1'b0) begin n_bad++; $display("FAIL mid_redir: got %b want 0", redir_valid); end
    n_cmp++; if (redir_pc !== 32'h0) begin n_bad++; $display("FAIL mid_redir_pc: got %h want 0", redir_pc); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_empty: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jalr();
    test_jal_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
